// File: rtl/fft4_stream.sv
// fft4_stream
// Streaming complex 4-point DFT/IDFT engine.
// Collects one frame of four complex samples in natural order, computes all
// four bins in a single registered stage, then emits the bins serially in
// natural order.
//
// Parameters:
//   DATA_W    signed width of each input component (4..16)
//   SCALE_OUT 0 = full-precision bins, 1 = each bin component floor-divided by 4
//   OUT_W     output component width, DATA_W+2 (wide enough for any input)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid
//   in_ready   block can accept a sample (only while loading a frame)
//   in_re      signed sample real part
//   in_im      signed sample imaginary part
//   in_inverse frame mode, taken with sample 0 only: 0 = forward, 1 = inverse
//   out_valid  output bin valid
//   out_ready  downstream accepts the bin
//   out_re     signed bin real part
//   out_im     signed bin imaginary part
//   out_idx    bin index 0..3
//   out_last   high with bin 3
module fft4_stream #(
  parameter int DATA_W = 9,
  parameter int SCALE_OUT = 0,
  localparam int OUT_W = DATA_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                    in_inverse,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic [1:0]              out_idx,
  output logic                    out_last
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  state_t state, state_nxt;

  logic [1:0] cnt;
  logic [1:0] idx;
  logic       inv;
  logic       in_fire;
  logic       out_fire;

  logic signed [DATA_W-1:0] x_re [4];
  logic signed [DATA_W-1:0] x_im [4];
  logic signed [OUT_W-1:0]  bin_re [4];
  logic signed [OUT_W-1:0]  bin_im [4];
  logic signed [OUT_W-1:0]  full_re [4];
  logic signed [OUT_W-1:0]  full_im [4];
  logic signed [OUT_W-1:0]  calc_re [4];
  logic signed [OUT_W-1:0]  calc_im [4];

  logic signed [DATA_W:0] s0_re, s0_im, s1_re, s1_im;
  logic signed [DATA_W:0] t0_re, t0_im, t1_re, t1_im;

  // Each butterfly level widens by one bit with explicit sign extension.
  function automatic logic signed [DATA_W:0] ext1(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  function automatic logic signed [OUT_W-1:0] ext2(input logic signed [DATA_W:0] v);
    return {v[DATA_W], v};
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are gated by out_valid so nothing but zeros leaves the block
  // outside OUTPUT, including straight after a reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_idx   = idx;
    out_re    = '0;
    out_im    = '0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire && cnt == 2'd3) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        state_nxt = OUTPUT;
      end
      OUTPUT: begin
        out_valid = 1'b1;
        out_last  = (idx == 2'd3);
        out_re    = bin_re[idx];
        out_im    = bin_im[idx];
        if (out_ready && idx == 2'd3) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Radix-2 butterflies. Multiplying by +/-j only swaps components and
  // flips a sign, so the inverse transform is the forward one with X1 and
  // X3 exchanged.
  always_comb begin
    s0_re = ext1(x_re[0]) + ext1(x_re[2]);
    s0_im = ext1(x_im[0]) + ext1(x_im[2]);
    s1_re = ext1(x_re[1]) + ext1(x_re[3]);
    s1_im = ext1(x_im[1]) + ext1(x_im[3]);
    t0_re = ext1(x_re[0]) - ext1(x_re[2]);
    t0_im = ext1(x_im[0]) - ext1(x_im[2]);
    t1_re = ext1(x_re[1]) - ext1(x_re[3]);
    t1_im = ext1(x_im[1]) - ext1(x_im[3]);

    full_re[0] = ext2(s0_re) + ext2(s1_re);
    full_im[0] = ext2(s0_im) + ext2(s1_im);
    full_re[2] = ext2(s0_re) - ext2(s1_re);
    full_im[2] = ext2(s0_im) - ext2(s1_im);
    full_re[1] = ext2(t0_re) + ext2(t1_im);
    full_im[1] = ext2(t0_im) - ext2(t1_re);
    full_re[3] = ext2(t0_re) - ext2(t1_im);
    full_im[3] = ext2(t0_im) + ext2(t1_re);

    if (inv) begin
      full_re[1] = ext2(t0_re) - ext2(t1_im);
      full_im[1] = ext2(t0_im) + ext2(t1_re);
      full_re[3] = ext2(t0_re) + ext2(t1_im);
      full_im[3] = ext2(t0_im) - ext2(t1_re);
    end

    for (int k = 0; k < 4; k++) begin
      calc_re[k] = (SCALE_OUT != 0) ? (full_re[k] >>> 2) : full_re[k];
      calc_im[k] = (SCALE_OUT != 0) ? (full_im[k] >>> 2) : full_im[k];
    end
  end

  // Sample buffer, frame mode, bin buffer and output index. The 2-bit
  // counters wrap on their own after sample 3 and bin 3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      inv <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        x_re[k]   <= '0;
        x_im[k]   <= '0;
        bin_re[k] <= '0;
        bin_im[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            x_re[cnt] <= in_re;
            x_im[cnt] <= in_im;
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd0) inv <= in_inverse;
          end
        end
        COMPUTE: begin
          for (int k = 0; k < 4; k++) begin
            bin_re[k] <= calc_re[k];
            bin_im[k] <= calc_im[k];
          end
        end
        OUTPUT: begin
          if (out_fire) idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_stream.sv
// tb_fft4_stream
// Directed bench for fft4_stream. Two instances share the input stimulus:
// one full precision, one with output scaling. Each frame selects which
// instance's outputs are compared.
module tb_fft4_stream;

  localparam int DATA_W = 9;
  localparam int OUT_W  = DATA_W + 2;

  typedef struct packed {
    logic [3:0][15:0] re;
    logic [3:0][15:0] im;
    logic             inv0;
    logic             invRest;
    logic             scaled;
    logic [3:0][15:0] eRe;
    logic [3:0][15:0] eIm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_inverse = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DATA_W-1:0] in_re = '0;
  logic signed [DATA_W-1:0] in_im = '0;

  logic in_ready_f, out_valid_f, out_last_f;
  logic [1:0] out_idx_f;
  logic signed [OUT_W-1:0] out_re_f, out_im_f;
  logic in_ready_s, out_valid_s, out_last_s;
  logic [1:0] out_idx_s;
  logic signed [OUT_W-1:0] out_re_s, out_im_s;

  logic useS = 1'b0;
  logic rdy, vld, lst;
  logic [1:0] idx;
  logic signed [OUT_W-1:0] ore, oim;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tA, tB;

  vec_t tbl [10];

  fft4_stream #(.DATA_W(DATA_W), .SCALE_OUT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_f),
    .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
    .out_valid(out_valid_f), .out_ready(out_ready),
    .out_re(out_re_f), .out_im(out_im_f),
    .out_idx(out_idx_f), .out_last(out_last_f)
  );

  fft4_stream #(.DATA_W(DATA_W), .SCALE_OUT(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_re(in_re), .in_im(in_im), .in_inverse(in_inverse),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_re(out_re_s), .out_im(out_im_s),
    .out_idx(out_idx_s), .out_last(out_last_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    rdy = useS ? in_ready_s  : in_ready_f;
    vld = useS ? out_valid_s : out_valid_f;
    lst = useS ? out_last_s  : out_last_f;
    idx = useS ? out_idx_s   : out_idx_f;
    ore = useS ? out_re_s    : out_re_f;
    oim = useS ? out_im_s    : out_im_f;
  end

  function automatic logic [3:0][15:0] pk(input int a0, input int a1, input int a2, input int a3);
    pk[0] = a0[15:0];
    pk[1] = a1[15:0];
    pk[2] = a2[15:0];
    pk[3] = a3[15:0];
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offers one sample and waits (bounded) until it is taken.
  task automatic applySample(input int re, input int im, input logic inv);
    int waitCnt;
    logic [15:0] r16, i16;
    r16 = re[15:0];
    i16 = im[15:0];
    in_re      = r16[DATA_W-1:0];
    in_im      = i16[DATA_W-1:0];
    in_inverse = inv;
    in_valid   = 1'b1;
    waitCnt    = 0;
    while (!rdy && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!rdy) checkOutput("sample accept timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Loads a full frame back to back and checks the 2-cycle latency to bin 0.
  task automatic applyStimulus(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) begin
      applySample(int'($signed(v.re[i])), int'($signed(v.im[i])),
                  (i == 0) ? v.inv0 : v.invRest);
    end
    checkOutput({tag, " valid early"}, int'(vld), 0);
    checkOutput({tag, " ready in compute"}, int'(rdy), 0);
    @(posedge clk); #1;
    checkOutput({tag, " valid latency"}, int'(vld), 1);
  endtask

  task automatic checkBin(input int k, input vec_t v, input string tag);
    checkOutput($sformatf("%s bin%0d valid", tag, k), int'(vld), 1);
    checkOutput($sformatf("%s bin%0d idx", tag, k), int'(idx), k);
    checkOutput($sformatf("%s bin%0d last", tag, k), int'(lst), (k == 3) ? 1 : 0);
    checkOutput($sformatf("%s bin%0d re", tag, k), int'(ore), int'($signed(v.eRe[k])));
    checkOutput($sformatf("%s bin%0d im", tag, k), int'(oim), int'($signed(v.eIm[k])));
    checkOutput($sformatf("%s bin%0d in_ready", tag, k), int'(rdy), 0);
  endtask

  task automatic collectBins(input vec_t v, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkBin(k, v, tag);
      @(posedge clk); #1;
    end
    checkOutput({tag, " valid after frame"}, int'(vld), 0);
    checkOutput({tag, " ready after frame"}, int'(rdy), 1);
  endtask

  task automatic pulseReset();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset valid", int'(vld), 0);
    checkOutput("reset re", int'(ore), 0);
    checkOutput("reset im", int'(oim), 0);
    checkOutput("reset idx", int'(idx), 0);
    checkOutput("reset last", int'(lst), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready after reset", int'(rdy), 1);
  endtask

  initial begin
    // in fields: re, im, inv0, invRest, scaled, expected re, expected im
    tbl[0] = '{pk(1,0,0,0), pk(0,0,0,0), 1'b0, 1'b0, 1'b0,
               pk(1,1,1,1), pk(0,0,0,0)};
    tbl[1] = '{pk(0,1,0,0), pk(0,0,0,0), 1'b0, 1'b0, 1'b0,
               pk(1,0,-1,0), pk(0,-1,0,1)};
    tbl[2] = '{pk(0,1,0,0), pk(0,0,0,0), 1'b1, 1'b1, 1'b0,
               pk(1,0,-1,0), pk(0,1,0,-1)};
    tbl[3] = '{pk(0,1,0,0), pk(0,0,0,0), 1'b0, 1'b1, 1'b0,
               pk(1,0,-1,0), pk(0,-1,0,1)};
    tbl[4] = '{pk(-256,-256,-256,-256), pk(-256,-256,-256,-256), 1'b0, 1'b0, 1'b0,
               pk(-1024,0,0,0), pk(-1024,0,0,0)};
    tbl[5] = '{pk(255,255,255,255), pk(-256,-256,-256,-256), 1'b0, 1'b0, 1'b0,
               pk(1020,0,0,0), pk(-1024,0,0,0)};
    tbl[6] = '{pk(1,3,-2,0), pk(2,-1,0,4), 1'b0, 1'b0, 1'b0,
               pk(2,-2,-4,8), pk(5,-1,-1,5)};
    tbl[7] = '{pk(3,0,0,0), pk(0,0,0,0), 1'b0, 1'b0, 1'b1,
               pk(0,0,0,0), pk(0,0,0,0)};
    tbl[8] = '{pk(-1,0,0,0), pk(0,0,0,0), 1'b0, 1'b0, 1'b1,
               pk(-1,-1,-1,-1), pk(0,0,0,0)};
    tbl[9] = '{pk(4,4,4,4), pk(4,4,4,4), 1'b0, 1'b0, 1'b1,
               pk(4,0,0,0), pk(4,0,0,0)};

    #1;
    checkOutput("por valid", int'(vld), 0);
    checkOutput("por re", int'(ore), 0);
    checkOutput("por idx", int'(idx), 0);
    checkOutput("por last", int'(lst), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready after por", int'(rdy), 1);

    for (int i = 0; i < 10; i++) begin
      useS = tbl[i].scaled;
      #0;
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
      collectBins(tbl[i], $sformatf("vec%0d", i));
    end
    useS = 1'b0;

    // Input gaps, junk offered during compute/output, and backpressure on bin 1.
    $display("[TB] gaps and backpressure");
    for (int i = 0; i < 4; i++) begin
      in_re = 9'sd77;
      in_im = -9'sd77;
      for (int g = 0; g <= i; g++) begin
        @(posedge clk); #1;
      end
      applySample(int'($signed(tbl[6].re[i])), int'($signed(tbl[6].im[i])), 1'b0);
    end
    in_re = 9'sd99;
    in_im = 9'sd99;
    in_inverse = 1'b1;
    in_valid = 1'b1;
    checkOutput("gap valid early", int'(vld), 0);
    @(posedge clk); #1;
    checkBin(0, tbl[6], "gap");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      checkBin(1, tbl[6], $sformatf("hold%0d", h));
      @(posedge clk); #1;
    end
    checkBin(1, tbl[6], "hold3");
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkBin(2, tbl[6], "gap");
    @(posedge clk); #1;
    checkBin(3, tbl[6], "gap");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_inverse = 1'b0;
    checkOutput("gap valid after", int'(vld), 0);
    applyStimulus(tbl[0], "after junk");
    collectBins(tbl[0], "after junk");

    // Back-to-back frames with out_ready high: 9-cycle period.
    $display("[TB] back-to-back period");
    applyStimulus(tbl[1], "b2b A");
    tA = cyc;
    collectBins(tbl[1], "b2b A");
    applyStimulus(tbl[2], "b2b B");
    tB = cyc;
    collectBins(tbl[2], "b2b B");
    checkOutput("frame period", tB - tA, 9);

    // Reset in the middle of loading.
    $display("[TB] reset mid-load");
    applySample(7, 7, 1'b1);
    applySample(7, 7, 1'b1);
    pulseReset();
    applyStimulus(tbl[1], "post load reset");
    collectBins(tbl[1], "post load reset");

    // Reset while bin 2 is on the output.
    $display("[TB] reset mid-output");
    applyStimulus(tbl[6], "pre out reset");
    checkBin(0, tbl[6], "pre out reset");
    @(posedge clk); #1;
    checkBin(1, tbl[6], "pre out reset");
    @(posedge clk); #1;
    checkBin(2, tbl[6], "pre out reset");
    pulseReset();
    checkOutput("no bins after reset", int'(vld), 0);
    applyStimulus(tbl[3], "post out reset");
    collectBins(tbl[3], "post out reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "[TB] timeout");
  end

endmodule
